// File: rtl/hazard_unit.sv
// Load-use hazard detection and operand forwarding select for an in-order pipeline.
// Optional stall counter output enabled by defining HAZARD_UNIT_PERF_EN.

module hazard_stage_match #(
  parameter int AW = 5
) (
  input  logic          v,
  input  logic          wreg,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src,
  input  logic          used,
  output logic          hit
);
  // r0 is hardwired zero, so it never produces a hit
  assign hit = v & wreg & used & (dst == src) & (src != '0);
endmodule

module hazard_unit #(
  parameter int AW         = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_dst,
  input  logic          id_load,
  input  logic          br_taken,
  output logic [2:0]    fwda,
  output logic [2:0]    fwdb,
  output logic          stall,
  output logic          flush_if
`ifdef HAZARD_UNIT_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic          v;
    logic          wreg;
    logic [AW-1:0] dst;
    logic          load;
  } entry_t;

  entry_t [STAGES:1] pipe;
  entry_t            ent_in;
  logic   [STAGES:1] hit_a, hit_b;
  logic              ld_a, ld_b;

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    hazard_stage_match #(.AW(AW)) u_ma (
      .v(pipe[g].v), .wreg(pipe[g].wreg), .dst(pipe[g].dst),
      .src(id_rs), .used(id_rs_used), .hit(hit_a[g])
    );
    hazard_stage_match #(.AW(AW)) u_mb (
      .v(pipe[g].v), .wreg(pipe[g].wreg), .dst(pipe[g].dst),
      .src(id_rt), .used(id_rt_used), .hit(hit_b[g])
    );
  end

  // Scan oldest to youngest so the youngest producer overwrites; a younger
  // non-load hit thereby clears an older load's stall request.
  always_comb begin
    fwda = '0;
    fwdb = '0;
    ld_a = 1'b0;
    ld_b = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (hit_a[k]) begin
        fwda = 3'(k);
        ld_a = pipe[k].load && (k < LOAD_STAGE);
      end
      if (hit_b[k]) begin
        fwdb = 3'(k);
        ld_b = pipe[k].load && (k < LOAD_STAGE);
      end
    end
  end

  assign stall    = id_valid & (ld_a | ld_b);
  assign flush_if = br_taken & id_valid & ~stall;

  always_comb begin
    ent_in      = '0;
    ent_in.v    = id_valid;
    ent_in.wreg = id_wreg;
    ent_in.dst  = id_dst;
    ent_in.load = id_load;
  end

  // A stalled ID instruction stays put, so a bubble enters stage 1 instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[1] <= stall ? entry_t'('0) : ent_in;
      for (int k = 2; k <= STAGES; k++) pipe[k] <= pipe[k-1];
    end
  end

`ifdef HAZARD_UNIT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed checks of forwarding select, load-use stall, branch flush and reset.
// Stall counter checks compile in only with HAZARD_UNIT_PERF_EN.

module tb_hazard_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_rs_used, id_rt_used, id_wreg, id_load, br_taken;
  logic [2:0] fwda, fwdb;
  logic       stall, flush_if;
`ifdef HAZARD_UNIT_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hazard_unit #(.AW(5), .STAGES(3), .LOAD_STAGE(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wreg(id_wreg), .id_dst(id_dst), .id_load(id_load), .br_taken(br_taken),
    .fwda(fwda), .fwdb(fwdb), .stall(stall), .flush_if(flush_if)
`ifdef HAZARD_UNIT_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic w,
                        input logic [4:0] d, input logic ld, input logic br);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wreg = w; id_dst = d; id_load = ld; br_taken = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    vecs++;
    if (stall !== 1'b0 || flush_if !== 1'b0 || fwda !== 3'd0 || fwdb !== 3'd0) begin
      errs++;
      $display("FAIL reset_outputs: stall=%b flush=%b fwda=%0d fwdb=%0d, want 0 0 0 0",
               stall, flush_if, fwda, fwdb);
    end
`ifdef HAZARD_UNIT_PERF_EN
    vecs++;
    if (stall_cnt !== 32'd0) begin
      errs++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
`endif
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_forward();
    logic [2:0] exp_fwd [4];
    exp_fwd = '{3'd1, 3'd2, 3'd3, 3'd0};
    drain();
    set_id(1, 0, 0, 0, 0, 1, 3, 0, 0);   // add r3
    step();
    set_id(1, 3, 0, 0, 0, 0, 0, 0, 0);   // reads r3 but rs_used=0
    #1;
    vecs++;
    if (fwda !== 3'd0) begin
      errs++; $display("FAIL fwd_unused: fwda=%0d want 0", fwda);
    end
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++;
      if (fwda !== exp_fwd[i] || stall !== 1'b0 || fwdb !== 3'd0) begin
        errs++;
        $display("FAIL fwd_age%0d: fwda=%0d stall=%b fwdb=%0d, want %0d 0 0",
                 i, fwda, stall, fwdb, exp_fwd[i]);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1, 0, 0, 0, 0, 1, 5, 1, 0);   // lw r5
    step();
    set_id(1, 0, 0, 5, 1, 0, 0, 0, 0);   // reads rt=r5
    #1;
    vecs++;
    if (stall !== 1'b1 || fwdb !== 3'd1) begin
      errs++; $display("FAIL lu_stall: stall=%b fwdb=%0d want 1 1", stall, fwdb);
    end
    step();
    vecs++;
    if (stall !== 1'b0 || fwdb !== 3'd2) begin
      errs++; $display("FAIL lu_release: stall=%b fwdb=%0d want 0 2", stall, fwdb);
    end
    // stage 1 must now hold a bubble, not the lw
    set_id(1, 5, 1, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++;
    if (fwda !== 3'd2) begin
      errs++; $display("FAIL lu_bubble: fwda=%0d want 2", fwda);
    end
  endtask

  task automatic test_both_sources();
    drain();
    set_id(1, 0, 0, 0, 0, 1, 6, 1, 0);   // lw r6
    step();
    set_id(1, 6, 1, 6, 1, 0, 0, 0, 0);
    #1;
    vecs++;
    if (stall !== 1'b1) begin
      errs++; $display("FAIL both_stall: stall=%b want 1", stall);
    end
    step();
    vecs++;
    if (stall !== 1'b0 || fwda !== 3'd2 || fwdb !== 3'd2) begin
      errs++; $display("FAIL both_release: stall=%b fwda=%0d fwdb=%0d want 0 2 2",
                       stall, fwda, fwdb);
    end
  endtask

  task automatic test_mask();
    drain();
    set_id(1, 0, 0, 0, 0, 1, 4, 1, 0);   // lw r4
    step();
    set_id(1, 0, 0, 0, 0, 1, 4, 0, 0);   // add r4
    step();
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++;
    if (fwda !== 3'd1 || stall !== 1'b0) begin
      errs++; $display("FAIL mask: fwda=%0d stall=%b want 1 0", fwda, stall);
    end
  endtask

  task automatic test_branch();
    drain();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    vecs++;
    if (flush_if !== 1'b1) begin
      errs++; $display("FAIL br_plain: flush_if=%b want 1", flush_if);
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    vecs++;
    if (flush_if !== 1'b0) begin
      errs++; $display("FAIL br_invalid: flush_if=%b want 0", flush_if);
    end
    set_id(1, 0, 0, 0, 0, 1, 7, 1, 0);   // lw r7
    step();
    set_id(1, 7, 1, 0, 0, 0, 0, 0, 1);   // branch on r7
    #1;
    vecs++;
    if (stall !== 1'b1 || flush_if !== 1'b0) begin
      errs++; $display("FAIL br_stalled: stall=%b flush_if=%b want 1 0", stall, flush_if);
    end
    step();
    vecs++;
    if (stall !== 1'b0 || flush_if !== 1'b1) begin
      errs++; $display("FAIL br_after: stall=%b flush_if=%b want 0 1", stall, flush_if);
    end
  endtask

  task automatic test_r0();
    drain();
    set_id(1, 0, 0, 0, 0, 1, 0, 1, 0);   // lw r0
    step();
    set_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
    #1;
    vecs++;
    if (stall !== 1'b0 || fwda !== 3'd0 || fwdb !== 3'd0) begin
      errs++; $display("FAIL r0: stall=%b fwda=%0d fwdb=%0d want 0 0 0", stall, fwda, fwdb);
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(1, 0, 0, 0, 0, 1, 9, 1, 0);   // lw r9
    step();
    set_id(1, 9, 1, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++;
    if (stall !== 1'b1) begin
      errs++; $display("FAIL mid_pre: stall=%b want 1", stall);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (stall !== 1'b0 || fwda !== 3'd0) begin
      errs++; $display("FAIL mid_reset: stall=%b fwda=%0d want 0 0", stall, fwda);
    end
`ifdef HAZARD_UNIT_PERF_EN
    vecs++;
    if (stall_cnt !== 32'd0) begin
      errs++; $display("FAIL mid_cnt: got %0d want 0", stall_cnt);
    end
`endif
    set_id(1, 0, 0, 0, 0, 1, 10, 0, 0);  // add r10
    #1 rst_n = 1'b1;
    step();
    set_id(1, 10, 1, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++;
    if (fwda !== 3'd1 || stall !== 1'b0) begin
      errs++; $display("FAIL post_reset_load: fwda=%0d stall=%b want 1 0", fwda, stall);
    end
    for (int i = 0; i < 3; i++) begin
      set_id(1, 0, 0, 0, 0, 1, 11, 1, 0);
      step();
      set_id(1, 0, 0, 11, 1, 0, 0, 0, 0);
      #1;
      vecs++;
      if (stall !== 1'b1) begin
        errs++; $display("FAIL forced_stall%0d: stall=%b want 1", i, stall);
      end
      step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
`ifdef HAZARD_UNIT_PERF_EN
    vecs++;
    if (stall_cnt !== 32'd3) begin
      errs++; $display("FAIL cnt3: got %0d want 3", stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_both_sources();
    test_mask();
    test_branch();
    test_r0();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter AW, default 5: register address width.
REQ-002 Parameter STAGES, default 3: number of tracked stages after ID (1=EXE, 2=MEM, 3=WB); legal range 1..7.
REQ-003 Parameter LOAD_STAGE, default 2: first tracked stage whose load data is forwardable; legal range 1..STAGES.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_rs, id_rt  in  AW each  ID source register addresses.
REQ-008 id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-009 id_wreg  in  1  ID instruction writes the register file.
REQ-010 id_dst  in  AW  ID destination register.
REQ-011 id_load  in  1  ID instruction is a load.
REQ-012 br_taken  in  1  ID resolved a taken branch/jump.
REQ-013 fwda, fwdb  out  3  forward select: 0 = register file, k = tracked stage k.
REQ-014 stall  out  1  hold PC and IF/ID; insert bubble into EXE.
REQ-015 flush_if  out  1  squash the instruction in IF.

Function
REQ-016 The unit SHALL keep an internal shift register pipe[1..STAGES], each entry {v, wreg, dst, load}.
REQ-017 Each edge, pipe[k+1] SHALL take pipe[k] for k = 1..STAGES-1; pipe[STAGES] is discarded.
REQ-018 pipe[1] SHALL load {id_valid, id_wreg, id_dst, id_load} when stall=0, else an all-zero bubble.
REQ-019 Entry k matches source s when v & wreg & dst==s & s!=0 & the source-used flag is set.
REQ-020 fwda/fwdb SHALL select the smallest matching k (youngest producer), else 0; outputs are combinational from the current pipe and ID inputs.
REQ-021 stall SHALL be 1 when id_valid and either source matches an entry k with load=1 and k < LOAD_STAGE.
REQ-022 Simultaneous rs and rt hazards SHALL produce a single stall, with no double counting.
REQ-023 A younger non-load match SHALL mask an older load match, because the youngest producer wins.
REQ-024 flush_if SHALL equal br_taken & id_valid & ~stall; stall has priority and the branch re-resolves next cycle.
REQ-025 Register 0 SHALL never cause a stall or a nonzero forward select.
REQ-026 A stall SHALL last exactly LOAD_STAGE-k cycles for a load at stage k, then release automatically as the bubble propagates.

Reset
REQ-027 While rst_n=0, all pipe entries SHALL clear asynchronously; stall=0, flush_if=0, fwda=fwdb=0 given id_valid=0.
REQ-028 Reset asserted mid-stall SHALL drop stall immediately; the first edge after release loads pipe[1] normally.

Configuration
REQ-029 Macro HAZARD_UNIT_PERF_EN: when defined, the unit SHALL add output stall_cnt (32 bits), cleared on reset, +1 per cycle with stall=1, saturating at 0xFFFFFFFF.
REQ-030 Without HAZARD_UNIT_PERF_EN, the port and counter SHALL be absent, and all other behaviour is identical.

Verification (STAGES=3, LOAD_STAGE=2)
REQ-031 Case 1: add r3 into the pipe, next ID reads rs=r3 -> fwda=1, stall=0; one cycle later the same read -> fwda=2, then 3, then 0.
REQ-032 Case 2: lw r5, next ID reads rt=r5 -> stall=1 for exactly 1 cycle, then fwdb=2; pipe[1] holds a bubble.
REQ-033 Case 3: add r4 in stage 1 and lw r4 in stage 2, ID reads r4 -> fwda=1, stall=0.
REQ-034 Case 4: br_taken=1 with no hazard -> flush_if=1; br_taken=1 during a load-use stall -> flush_if=0, then flush_if=1 on the following cycle.
REQ-035 Case 5: ID reads r0 while pipe[1] writes r0 with load=1 -> stall=0, fwda=0.
REQ-036 Case 6: drop rst_n during a stall -> stall=0 at once and the pipe clears; with PERF_EN, stall_cnt=0, and 3 forced stalls -> stall_cnt=3.
